mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: mem_read  in  1 and mem_write  in  1, the load/store request from EX/MEM.
REQ-004 SHALL have: funct3  in  3  access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-005 SHALL have: addr  in  32 and store_data  in  32, the byte address and the unaligned store value.
REQ-006 SHALL have: dm_req  out  1, dm_we  out  1, dm_addr  out  32 (word-aligned), dm_wstrb  out  4 and dm_wdata  out  32, the data-memory request.
REQ-007 SHALL have: dm_ready  in  1 and dm_rdata  in  32, the data-memory completion and read word.
REQ-008 SHALL have: waiting  out  1, the pipeline stall that drives the MEM/WB hold.
REQ-009 SHALL have: load_data  out  32, the aligned, extended load result that feeds MEM/WB DM_data_in.
REQ-010 SHALL have: misalign  out  1, a one-cycle misaligned-access pulse.

Function
REQ-011 SHALL implement an FSM with states IDLE, ACCESS and DONE.
REQ-012 In IDLE with mem_read|mem_write=1: SHALL assert waiting combinationally, register dm_addr, dm_we, dm_wstrb and dm_wdata, and go to ACCESS.
REQ-013 If mem_read and mem_write are both 1, SHALL treat the request as a write.
REQ-014 In ACCESS: dm_req=1, waiting=1, and request fields SHALL stay stable until the dm_ready cycle.
REQ-015 In ACCESS with dm_ready=1: SHALL register load_data (reads only) and go to DONE.
REQ-016 In DONE: waiting=0 and dm_req=0 for exactly one cycle, then IDLE; SHALL accept no request while in DONE.
REQ-017 Minimum stall SHALL be 2 cycles (IDLE→ACCESS, ACCESS with dm_ready in the first cycle); there is no upper bound.
REQ-018 In IDLE with no request: waiting=0, dm_req=0.
REQ-019 Load extraction: byte uses lane addr[1:0], half uses lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-020 Store: SB replicates the byte ×4 with wstrb=0001<<addr[1:0]; SH replicates the half ×2 with wstrb=0011<<{addr[1],0}; SW uses wstrb=1111.
REQ-021 load_data SHALL hold its value except on a read-completion cycle.
REQ-022 dm_ready outside ACCESS SHALL be ignored.

Reset
REQ-023 rst=0 SHALL immediately force IDLE with dm_req, dm_we and misalign at 0, and dm_addr, dm_wstrb, dm_wdata and load_data at 0.
REQ-024 Reset asserted during ACCESS SHALL abandon the access; any later dm_ready SHALL be ignored.

Configuration
REQ-025 With MEM_MISALIGN_CHECK_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, in IDLE SHALL pulse misalign for one cycle, issue no dm_req, keep waiting=0, and leave load_data unchanged.
REQ-026 Without MEM_MISALIGN_CHECK_EN: misalign SHALL be tied to 0; half accesses ignore addr[0], word accesses ignore addr[1:0], and the access proceeds normally.

Structure
REQ-027 Package mem_pkg SHALL hold the state enum, the funct3 load/store constants and the wstrb patterns.
REQ-028 SHALL instantiate one combinational sub-module, load_align (dm_rdata, addr[1:0], funct3 → load_data value).

Verification
REQ-029 LB, addr=0x103, dm_rdata=0x80FF_1234, dm_ready on the first ACCESS cycle → load_data=0xFFFF_FF80, waiting high for 2 cycles then low for 1.
REQ-030 SH, addr=0x202, store_data=0x0000_ABCD → dm_addr=0x200, dm_wstrb=1100, dm_wdata=0xABCD_ABCD, dm_we=1.
REQ-031 LW with dm_ready delayed 5 cycles → waiting=1 for 6 cycles and dm_addr/dm_req stable throughout; then load_data=dm_rdata.
REQ-032 rst=0 on the 2nd ACCESS cycle, then dm_ready=1 after release → FSM in IDLE, load_data=0, no DONE cycle.
REQ-033 With MEM_MISALIGN_CHECK_EN, LW addr=0x101 → misalign=1 for 1 cycle, dm_req never asserted, waiting=0; without the macro → dm_addr=0x100 and normal completion.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types, funct3/size constants, store-lane patterns and request builder
// for the data-memory access controller.
package mem_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [3:0] WSTRB_B = 4'b0001;
    localparam logic [3:0] WSTRB_H = 4'b0011;
    localparam logic [3:0] WSTRB_W = 4'b1111;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [1:0]  lane;
        logic [2:0]  funct3;
    } req_t;

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == SZ_H) && a[0]) || ((f3[1:0] == SZ_W) && (a != 2'b00));
    endfunction

    // Lane offset and funct3 are kept so the read word can be aligned on completion.
    function automatic req_t build_req(input logic we, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] sd);
        req_t r;
        r        = '0;
        r.we     = we;
        r.addr   = {a[31:2], 2'b00};
        r.lane   = a[1:0];
        r.funct3 = f3;
        if (we) begin
            case (f3[1:0])
                SZ_B: begin
                    r.wdata = {4{sd[7:0]}};
                    r.wstrb = WSTRB_B << a[1:0];
                end
                SZ_H: begin
                    r.wdata = {2{sd[15:0]}};
                    r.wstrb = WSTRB_H << {a[1], 1'b0};
                end
                default: begin
                    r.wdata = sd;
                    r.wstrb = WSTRB_W;
                end
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[8*lane +: 8];
    assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_HU:   data = {16'h0, half_sel};
            F3_W:    data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front end between EX/MEM and a handshaked data memory.
// Optional MEM_MISALIGN_CHECK_EN rejects misaligned half/word accesses with a misalign pulse.
module mem_access_ctrl
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic        waiting,
    output logic [31:0] load_data,
    output logic        misalign
);

    state_t      state, state_nxt;
    req_t        req_q;
    logic        req_any, bad_align, accept;
    logic [31:0] align_data;

    assign req_any = mem_read | mem_write;

`ifdef MEM_MISALIGN_CHECK_EN
    assign bad_align = misaligned(funct3, addr[1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misalign <= 1'b0;
        else      misalign <= (state == S_IDLE) && req_any && bad_align;
    end
`else
    assign bad_align = 1'b0;
    assign misalign  = 1'b0;
`endif

    assign accept = (state == S_IDLE) && req_any && !bad_align;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_ACCESS;
            S_ACCESS: if (dm_ready) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Stall starts combinationally on the accepting cycle so EX/MEM holds immediately.
    always_comb begin
        waiting = 1'b0;
        dm_req  = 1'b0;
        case (state)
            S_IDLE:   waiting = accept;
            S_ACCESS: begin
                waiting = 1'b1;
                dm_req  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q     <= '0;
            load_data <= '0;
        end else begin
            if (accept)
                req_q <= build_req(mem_write, funct3, addr, store_data);
            if ((state == S_ACCESS) && dm_ready && !req_q.we)
                load_data <= align_data;
        end
    end

    load_align u_align (
        .rdata  (dm_rdata),
        .lane   (req_q.lane),
        .funct3 (req_q.funct3),
        .data   (align_data)
    );

    assign dm_we    = req_q.we;
    assign dm_addr  = req_q.addr;
    assign dm_wstrb = req_q.wstrb;
    assign dm_wdata = req_q.wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against an arithmetic load/store model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = '0, store_data = '0;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        dm_ready = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        waiting, misalign;
    logic [31:0] load_data;

    int          checks = 0, failures = 0;
    logic [31:0] model_ld = '0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .waiting(waiting), .load_data(load_data), .misalign(misalign)
    );

    // Reference: pick the addressed field arithmetically and extend it.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        int v;
        case (f3)
            3'b000: begin v = int'((w >> (8 * a[1:0])) & 32'hFF);   if (v > 127)   v = v - 256;   end
            3'b001: begin v = int'((w >> (16 * a[1])) & 32'hFFFF);  if (v > 32767) v = v - 65536; end
            3'b100: v = int'((w >> (8 * a[1:0])) & 32'hFF);
            3'b101: v = int'((w >> (16 * a[1])) & 32'hFFFF);
            default: v = int'(w);
        endcase
        return 32'(v);
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
        case (f3[1:0])
            2'b00:   return 4'(1 << a[1:0]);
            2'b01:   return 4'(3 << (2 * a[1]));
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3[1:0])
            2'b00:   return (sd & 32'hFF) * 32'h0101_0101;
            2'b01:   return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    // Drives one access with dm_ready on ACCESS cycle 'delay' and reports what it observed.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd, input int delay,
                              input logic [31:0] rdata,
                              output int n_wait, output int n_req, output logic stable,
                              output logic done_ok, output logic [31:0] o_addr,
                              output logic [3:0] o_strb, output logic [31:0] o_wdata,
                              output logic o_we);
        n_wait = 0; n_req = 0; stable = 1'b1; done_ok = 1'b0;
        o_addr = '0; o_strb = '0; o_wdata = '0; o_we = 1'b0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        dm_ready = 1'b0; dm_rdata = $urandom;
        #1;
        if (waiting === 1'b1) n_wait++;
        if (dm_req === 1'b1) n_req++;
        for (int c = 1; c <= delay; c++) begin
            @(negedge clk);
            dm_ready = (c == delay);
            dm_rdata = (c == delay) ? rdata : $urandom;
            #1;
            if (waiting === 1'b1) n_wait++;
            if (dm_req === 1'b1) n_req++;
            if (c == 1) begin
                o_addr = dm_addr; o_strb = dm_wstrb; o_wdata = dm_wdata; o_we = dm_we;
            end else if ({dm_addr, dm_wstrb, dm_wdata, dm_we, dm_req} !==
                         {o_addr, o_strb, o_wdata, o_we, 1'b1}) begin
                stable = 1'b0;
            end
        end
        @(negedge clk);
        dm_ready = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        #1;
        done_ok = (waiting === 1'b0) && (dm_req === 1'b0);
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        checks++; if ({dm_req, dm_we, waiting, misalign} !== 4'b0) begin failures++;
            $display("FAIL reset_ctrl got=%b exp=0000", {dm_req, dm_we, waiting, misalign}); end
        checks++; if ({dm_addr, dm_wstrb, dm_wdata, load_data} !== '0) begin failures++;
            $display("FAIL reset_data got addr=%h strb=%b wdata=%h ld=%h exp all 0",
                     dm_addr, dm_wstrb, dm_wdata, load_data); end
    endtask

    task automatic test_lb_example;
        int nw, nr; logic st, dn, we; logic [31:0] ad, wd; logic [3:0] sb;
        run_access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_1234, nw, nr, st, dn, ad, sb, wd, we);
        model_ld = 32'hFFFF_FF80;
        checks++; if (load_data !== 32'hFFFF_FF80) begin failures++;
            $display("FAIL lb_data got=%h exp=ffffff80", load_data); end
        checks++; if (nw != 2 || !dn) begin failures++;
            $display("FAIL lb_stall got wait=%0d done_low=%b exp 2/1", nw, dn); end
        checks++; if (ad !== 32'h100 || we !== 1'b0) begin failures++;
            $display("FAIL lb_req got addr=%h we=%b exp 100/0", ad, we); end
    endtask

    task automatic test_sh_example;
        int nw, nr; logic st, dn, we; logic [31:0] ad, wd; logic [3:0] sb;
        run_access(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 1, 32'h0, nw, nr, st, dn, ad, sb, wd, we);
        checks++; if ({ad, sb, wd, we} !== {32'h200, 4'b1100, 32'hABCD_ABCD, 1'b1}) begin failures++;
            $display("FAIL sh_req got addr=%h strb=%b wdata=%h we=%b exp 200/1100/abcdabcd/1",
                     ad, sb, wd, we); end
        checks++; if (load_data !== model_ld) begin failures++;
            $display("FAIL sh_ld_hold got=%h exp=%h", load_data, model_ld); end
    endtask

    task automatic test_lw_delay;
        int nw, nr; logic st, dn, we; logic [31:0] ad, wd, rd; logic [3:0] sb;
        rd = $urandom;
        run_access(1, 0, 3'b010, 32'h0000_1F00, 32'h0, 5, rd, nw, nr, st, dn, ad, sb, wd, we);
        model_ld = rd;
        checks++; if (nw != 6 || nr != 5 || !st) begin failures++;
            $display("FAIL lw_delay got wait=%0d req=%0d stable=%b exp 6/5/1", nw, nr, st); end
        checks++; if (load_data !== rd || ad !== 32'h1F00) begin failures++;
            $display("FAIL lw_delay_data got ld=%h addr=%h exp %h/1f00", load_data, ad, rd); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        mem_read = 1; mem_write = 0; funct3 = 3'b101; addr = 32'h302; dm_ready = 0;
        #1;
        checks++; if (waiting !== 1'b1 || dm_req !== 1'b0) begin failures++;
            $display("FAIL b2b_accept got wait=%b req=%b exp 1/0", waiting, dm_req); end
        @(negedge clk); dm_ready = 1; dm_rdata = 32'hBEEF_0011; #1;
        checks++; if (dm_req !== 1'b1) begin failures++;
            $display("FAIL b2b_access got req=%b exp 1", dm_req); end
        @(negedge clk); dm_ready = 0; funct3 = 3'b010; addr = 32'h400; #1;
        model_ld = 32'h0000_BEEF;
        checks++; if (waiting !== 1'b0 || dm_req !== 1'b0 || load_data !== model_ld) begin failures++;
            $display("FAIL b2b_done got wait=%b req=%b ld=%h exp 0/0/%h", waiting, dm_req, load_data, model_ld); end
        @(negedge clk); #1;
        checks++; if (waiting !== 1'b1 || dm_req !== 1'b0) begin failures++;
            $display("FAIL b2b_idle got wait=%b req=%b exp 1/0", waiting, dm_req); end
        @(negedge clk); #1;
        checks++; if (dm_req !== 1'b1 || dm_addr !== 32'h400) begin failures++;
            $display("FAIL b2b_second got req=%b addr=%h exp 1/400", dm_req, dm_addr); end
        dm_ready = 1; dm_rdata = 32'h1357_9BDF;
        @(negedge clk); dm_ready = 0; mem_read = 0; #1;
        model_ld = 32'h1357_9BDF;
        checks++; if (load_data !== model_ld) begin failures++;
            $display("FAIL b2b_second_ld got=%h exp=%h", load_data, model_ld); end
    endtask

    task automatic test_ready_outside;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); dm_ready = 1; dm_rdata = $urandom; #1;
            checks++; if (dm_req !== 1'b0 || waiting !== 1'b0 || load_data !== model_ld) begin failures++;
                $display("FAIL ready_idle got req=%b wait=%b ld=%h exp 0/0/%h", dm_req, waiting, load_data, model_ld); end
        end
        @(negedge clk); dm_ready = 0;
    endtask

    task automatic test_misalign;
`ifdef MEM_MISALIGN_CHECK_EN
        logic [31:0] al [2];
        logic [2:0]  fs [2];
        al[0] = 32'h101; fs[0] = 3'b010;
        al[1] = 32'h203; fs[1] = 3'b001;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); mem_read = (k == 0); mem_write = (k == 1); funct3 = fs[k]; addr = al[k]; #1;
            checks++; if (waiting !== 1'b0 || dm_req !== 1'b0) begin failures++;
                $display("FAIL mis_nostall got wait=%b req=%b exp 0/0", waiting, dm_req); end
            @(negedge clk); mem_read = 0; mem_write = 0; #1;
            checks++; if (misalign !== 1'b1 || dm_req !== 1'b0) begin failures++;
                $display("FAIL mis_pulse got mis=%b req=%b exp 1/0", misalign, dm_req); end
            @(negedge clk); #1;
            checks++; if (misalign !== 1'b0 || dm_req !== 1'b0 || load_data !== model_ld) begin failures++;
                $display("FAIL mis_end got mis=%b req=%b ld=%h exp 0/0/%h", misalign, dm_req, load_data, model_ld); end
        end
`else
        int nw, nr; logic st, dn, we; logic [31:0] ad, wd, rd; logic [3:0] sb;
        rd = $urandom;
        run_access(1, 0, 3'b010, 32'h101, 32'h0, 2, rd, nw, nr, st, dn, ad, sb, wd, we);
        model_ld = rd;
        checks++; if (ad !== 32'h100 || nw != 3 || load_data !== rd || misalign !== 1'b0) begin failures++;
            $display("FAIL unaligned_lw got addr=%h wait=%0d ld=%h mis=%b exp 100/3/%h/0", ad, nw, load_data, misalign, rd); end
        rd = $urandom;
        run_access(1, 0, 3'b001, 32'h103, 32'h0, 1, rd, nw, nr, st, dn, ad, sb, wd, we);
        model_ld = ref_load(3'b001, 32'h103, rd);
        checks++; if (load_data !== model_ld) begin failures++;
            $display("FAIL unaligned_lh got=%h exp=%h", load_data, model_ld); end
`endif
    endtask

    task automatic test_random;
        logic [2:0]  ld_f3 [5];
        logic [2:0]  f3;
        logic [31:0] a, sd, rd, ad, wd;
        logic        r, w, st, dn, we;
        logic [3:0]  sb;
        int          dly, nw, nr, kind;
        ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            r = (kind != 1); w = (kind != 0);
            f3 = w ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            a = $urandom; sd = $urandom; rd = $urandom; dly = $urandom_range(1, 4);
`ifdef MEM_MISALIGN_CHECK_EN
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
`endif
            run_access(r, w, f3, a, sd, dly, rd, nw, nr, st, dn, ad, sb, wd, we);
            if (!w) model_ld = ref_load(f3, a, rd);
            checks++; if (nw != dly + 1 || nr != dly || !st || !dn) begin failures++;
                $display("FAIL rnd_timing n=%0d got wait=%0d req=%0d stable=%b done=%b exp %0d/%0d/1/1",
                         n, nw, nr, st, dn, dly + 1, dly); end
            checks++; if (ad !== {a[31:2], 2'b00} || we !== w) begin failures++;
                $display("FAIL rnd_req n=%0d got addr=%h we=%b exp %h/%b", n, ad, we, {a[31:2], 2'b00}, w); end
            if (w) begin
                checks++; if (sb !== ref_strb(f3, a) || wd !== ref_wdata(f3, sd)) begin failures++;
                    $display("FAIL rnd_store n=%0d got strb=%b wdata=%h exp %b/%h",
                             n, sb, wd, ref_strb(f3, a), ref_wdata(f3, sd)); end
            end
            checks++; if (load_data !== model_ld) begin failures++;
                $display("FAIL rnd_load n=%0d f3=%0d got=%h exp=%h", n, f3, load_data, model_ld); end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h500; dm_ready = 0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (dm_req !== 1'b1) begin failures++;
            $display("FAIL rmid_access got req=%b exp 1", dm_req); end
        rst = 0; mem_read = 0; #1;
        model_ld = '0;
        checks++; if (dm_req !== 1'b0 || waiting !== 1'b0 || load_data !== 32'h0 || dm_addr !== 32'h0) begin failures++;
            $display("FAIL rmid_reset got req=%b wait=%b ld=%h addr=%h exp 0/0/0/0", dm_req, waiting, load_data, dm_addr); end
        @(negedge clk); rst = 1; dm_ready = 1; dm_rdata = 32'hDEAD_BEEF; #1;
        checks++; if (dm_req !== 1'b0 || waiting !== 1'b0) begin failures++;
            $display("FAIL rmid_release got req=%b wait=%b exp 0/0", dm_req, waiting); end
        @(negedge clk); dm_ready = 0; mem_read = 1; #1;
        checks++; if (load_data !== 32'h0 || waiting !== 1'b1) begin failures++;
            $display("FAIL rmid_idle got ld=%h wait=%b exp 0/1", load_data, waiting); end
        @(negedge clk); dm_ready = 1; dm_rdata = 32'h0BAD_F00D;
        @(negedge clk); dm_ready = 0; mem_read = 0; #1;
        model_ld = 32'h0BAD_F00D;
        checks++; if (load_data !== model_ld) begin failures++;
            $display("FAIL rmid_after got=%h exp=%h", load_data, model_ld); end
    endtask

    initial begin
        rst = 0;
        repeat (2) @(negedge clk);
        test_reset;
        @(negedge clk); rst = 1;
        test_lb_example;
        test_sh_example;
        test_lw_delay;
        test_back_to_back;
        test_ready_outside;
        test_misalign;
        test_random;
        test_reset_mid;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
